vga_board_renderer: RTL and testbench

Pixel-rate renderer that reads the 3x3 game board state and drives the VGA connector. It generates 640x480@60 Hz timing from the 25 MHz VGA PLL clock and snapshots the board once per frame, during vertical blanking, so a frame never tears. It draws the grid, player-1 X marks, player-2 O rings and an optional cursor outline. It sits between the game FSM, which writes the board, and the VGA pins; it is the read side of the board register.

---
 rtl/vga_board_renderer.sv | 145 ++++++++++++++
 tb/tb_vga_board_renderer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_board_renderer.sv
// 640x480@60 renderer for the 3x3 board: raster counters, per-frame board snapshot
// taken in vertical blanking, and a single registered colour/sync output stage.
module vga_board_renderer (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [17:0] iBoard,
  input  logic [3:0]  iCursor,
  output logic        oHS,
  output logic        oVS,
  output logic [3:0]  oVGA_R,
  output logic [3:0]  oVGA_G,
  output logic [3:0]  oVGA_B,
  output logic        oFrame
);

  logic [9:0]  hc, vc;
  logic [17:0] board_q;
  logic [3:0]  cursor_q;

  logic        end_line, snap;
  logic        active_p0, in_board_p0, hs_p0, vs_p0;
  logic [8:0]  lx_p0, ly_p0, ox_p0, oy_p0;
  logic [1:0]  col_p0, row_p0, owner_p0;
  logic [3:0]  cell_p0;
  logic signed [9:0]  d1_p0, d2_p0, dx_p0, dy_p0;
  logic signed [15:0] sqx_p0, sqy_p0;
  logic [15:0] r2_p0;
  logic        grid_p0, xmark_p0, ring_p0, cur_p0;
  logic [11:0] rgb_p0;

  function automatic logic in_rng(input logic [8:0] v, input logic [8:0] lo, input logic [8:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [1:0] band(input logic [8:0] l);
    if (l < 9'd120)      return 2'd0;
    else if (l < 9'd240) return 2'd1;
    else                 return 2'd2;
  endfunction

  // Offset within the cell by subtracting 0/120/240 instead of a multiply.
  function automatic logic [8:0] offs(input logic [8:0] l, input logic [1:0] b);
    case (b)
      2'd0:    return l;
      2'd1:    return l - 9'd120;
      default: return l - 9'd240;
    endcase
  endfunction

  function automatic logic near3(input logic signed [9:0] d);
    return (d >= -10'sd3) && (d <= 10'sd3);
  endfunction

  assign end_line = (hc == 10'd799);
  assign snap     = end_line && (vc == 10'd479);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else if (end_line) begin
      hc <= 10'd0;
      vc <= (vc == 10'd524) ? 10'd0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      board_q  <= 18'd0;
      cursor_q <= 4'hF;
    end else if (snap) begin
      board_q  <= iBoard;
      cursor_q <= iCursor;
    end
  end

  // Stage p0: geometry and mark decode from the current counter position.
  always_comb begin
    active_p0   = (hc < 10'd640) && (vc < 10'd480);
    in_board_p0 = (hc >= 10'd140) && (hc <= 10'd499) && (vc >= 10'd60) && (vc <= 10'd419);
    hs_p0       = !((hc >= 10'd656) && (hc <= 10'd751));
    vs_p0       = !((vc >= 10'd490) && (vc <= 10'd491));

    lx_p0  = hc[8:0] - 9'd140;
    ly_p0  = vc[8:0] - 9'd60;
    col_p0 = band(lx_p0);
    row_p0 = band(ly_p0);
    ox_p0  = offs(lx_p0, col_p0);
    oy_p0  = offs(ly_p0, row_p0);
    cell_p0 = {1'b0, row_p0, 1'b0} + {2'b00, row_p0} + {2'b00, col_p0};

    owner_p0 = 2'b00;
    for (int i = 0; i < 9; i++)
      if (cell_p0 == i[3:0]) owner_p0 = board_q[2*i +: 2];

    grid_p0 = in_rng(lx_p0, 9'd118, 9'd121) || in_rng(lx_p0, 9'd238, 9'd241) ||
              in_rng(ly_p0, 9'd118, 9'd121) || in_rng(ly_p0, 9'd238, 9'd241);

    d1_p0 = $signed({1'b0, ox_p0}) - $signed({1'b0, oy_p0});
    d2_p0 = $signed({1'b0, ox_p0}) + $signed({1'b0, oy_p0}) - 10'sd119;
    xmark_p0 = in_rng(ox_p0, 9'd16, 9'd103) && in_rng(oy_p0, 9'd16, 9'd103) &&
               (near3(d1_p0) || near3(d2_p0));

    dx_p0  = $signed({ox_p0, 1'b0}) - 10'sd119;
    dy_p0  = $signed({oy_p0, 1'b0}) - 10'sd119;
    sqx_p0 = dx_p0 * dx_p0;
    sqy_p0 = dy_p0 * dy_p0;
    r2_p0  = $unsigned(sqx_p0) + $unsigned(sqy_p0);
    ring_p0 = (r2_p0 >= 16'd6400) && (r2_p0 <= 16'd7744);

    cur_p0 = (cell_p0 == cursor_q) &&
             (in_rng(ox_p0, 9'd4, 9'd7) || in_rng(ox_p0, 9'd112, 9'd115) ||
              in_rng(oy_p0, 9'd4, 9'd7) || in_rng(oy_p0, 9'd112, 9'd115));

    rgb_p0 = 12'h000;
    if (active_p0 && in_board_p0) begin
      if (grid_p0)                             rgb_p0 = 12'hFFF;
      else if (owner_p0 == 2'b01 && xmark_p0)  rgb_p0 = 12'hF00;
      else if (owner_p0 == 2'b10 && ring_p0)   rgb_p0 = 12'h00F;
      else if (cur_p0)                         rgb_p0 = 12'hFF0;
    end
  end

  // Stage p1: registered outputs, colour and sync share the same one-cycle delay.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oHS    <= 1'b1;
      oVS    <= 1'b1;
      oVGA_R <= 4'h0;
      oVGA_G <= 4'h0;
      oVGA_B <= 4'h0;
      oFrame <= 1'b0;
    end else begin
      oHS    <= hs_p0;
      oVS    <= vs_p0;
      oVGA_R <= rgb_p0[11:8];
      oVGA_G <= rgb_p0[7:4];
      oVGA_B <= rgb_p0[3:0];
      oFrame <= snap;
    end
  end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer: raster-position model, pixel scoreboard and
// sync/frame-pulse monitor over several frames including a mid-frame reset.
module tb_vga_board_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] board = 18'd0;
  logic [3:0]  cursor = 4'd12;
  logic        hs, vs, frame;
  logic [3:0]  r, g, b;
  logic [11:0] rgb;

  assign rgb = {r, g, b};

  vga_board_renderer dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .iBoard   (board),
    .iCursor  (cursor),
    .oHS      (hs),
    .oVS      (vs),
    .oVGA_R   (r),
    .oVGA_G   (g),
    .oVGA_B   (b),
    .oFrame   (frame)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   yellow_cnt = 0;
  bit   chk_no_yellow = 0;

  // Raster model: m_* is the position the DUT is processing now, s_* the one
  // whose colour is on the outputs after the last edge.
  int   m_hc, m_vc, s_x, s_y;
  logic s_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hc  <= 0;
      m_vc  <= 0;
      s_x   <= 0;
      s_y   <= 0;
      s_vld <= 1'b0;
    end else begin
      s_x   <= m_hc;
      s_y   <= m_vc;
      s_vld <= 1'b1;
      if (m_hc == 799) begin
        m_hc <= 0;
        m_vc <= (m_vc == 524) ? 0 : m_vc + 1;
      end else begin
        m_hc <= m_hc + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (pos %0d,%0d t=%0t)", name, act, exp, s_x, s_y, $time);
    end
  endtask

  task automatic push(input int x, input int y, input logic [11:0] c, input string name);
    exp_t e;
    e.x = x; e.y = y; e.rgb = c; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_pos(input int x, input int y);
    int n = 0;
    while (!(m_hc == x && m_vc == y) && n < 500000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500000) begin
      tests++; fails++;
      $display("FAIL wait_pos: position (%0d,%0d) not reached", x, y);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame && n < 500000);
    if (!frame) begin
      tests++; fails++;
      $display("FAIL wait_frame: no oFrame pulse within %0d cycles", n);
    end
  endtask

  // Monitor: per-cycle sync/frame/blanking checks, scoreboard pops, pulse widths.
  initial begin
    int  cyc = 0, hs_lo = 0, vs_lo = 0;
    int  last_hs_fall = -1, last_vs_fall = -1, last_frame = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!s_vld) begin
        hs_lo = 0; vs_lo = 0;
        last_hs_fall = -1; last_vs_fall = -1; last_frame = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
      end else begin
        check("hs_level", int'(hs), (s_x >= 656 && s_x <= 751) ? 0 : 1);
        check("vs_level", int'(vs), (s_y >= 490 && s_y <= 491) ? 0 : 1);
        check("frame_pulse", int'(frame), (s_x == 799 && s_y == 479) ? 1 : 0);
        if (!(s_x < 640 && s_y < 480)) check("blank_rgb", int'(rgb), 0);
        if (sb.size() > 0 && sb[0].x == s_x && sb[0].y == s_y) begin
          e = sb.pop_front();
          check(e.name, int'(rgb), int'(e.rgb));
        end
        if (chk_no_yellow && rgb == 12'hFF0) yellow_cnt++;

        if (prev_hs && !hs) begin
          if (last_hs_fall >= 0) check("hs_period", cyc - last_hs_fall, 800);
          last_hs_fall = cyc;
        end
        if (!hs) hs_lo++;
        else if (hs_lo > 0) begin check("hs_low_width", hs_lo, 96); hs_lo = 0; end

        if (prev_vs && !vs) begin
          if (last_vs_fall >= 0) check("vs_period", cyc - last_vs_fall, 420000);
          last_vs_fall = cyc;
        end
        if (!vs) vs_lo++;
        else if (vs_lo > 0) begin check("vs_low_width", vs_lo, 1600); vs_lo = 0; end

        if (frame) begin
          if (last_frame >= 0) check("frame_period", cyc - last_frame, 420000);
          last_frame = cyc;
        end
        prev_hs = hs;
        prev_vs = vs;
        cyc++;
      end
    end
  end

  initial begin
    repeat (5) begin
      @(posedge clk); #1;
      check("rst_hs", int'(hs), 1);
      check("rst_vs", int'(vs), 1);
      check("rst_rgb", int'(rgb), 0);
      check("rst_frame", int'(frame), 0);
    end
    // Frame 0 renders the reset (empty) board even after iBoard changes.
    push(160,  80, 12'h000, "f0_cell0_black");
    push(160, 320, 12'h000, "f0_cell6_isolated");
    @(negedge clk);
    rst_n = 1'b1;

    wait_pos(0, 200);
    board = 18'h01201;   // cell0=P1, cell4=P2, cell6=P1
    wait_frame();

    chk_no_yellow = 1;
    push(160,  80, 12'hF00, "x_diag");
    push(100, 100, 12'h000, "outside_board");
    push(145, 100, 12'h000, "no_cursor");
    push(160, 100, 12'h000, "x_gap");
    push(319, 198, 12'h00F, "o_ring");
    push(258, 200, 12'hFFF, "grid_line");
    push(319, 239, 12'h000, "o_centre");
    push(160, 320, 12'hF00, "f1_cell6_red");
    wait_pos(0, 300);
    cursor = 4'd0;
    wait_frame();
    chk_no_yellow = 0;
    check("no_yellow_cursor12", yellow_cnt, 0);

    push(160,  80, 12'hF00, "x_over_cursor");
    push(145, 100, 12'hFF0, "cursor_edge");
    push(160, 100, 12'h000, "cursor_interior");
    wait_pos(300, 250);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hs", int'(hs), 1);
    check("midrst_vs", int'(vs), 1);
    check("midrst_rgb", int'(rgb), 0);
    check("midrst_frame", int'(frame), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    push(160,  80, 12'h000, "postrst_cell0_empty");
    push(145, 100, 12'h000, "postrst_no_cursor");
    push(319, 198, 12'h000, "postrst_cell4_empty");
    wait_pos(0, 420);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
